// File: rtl/spi_pixel_bridge.sv
// spi_pixel_bridge: sck-to-clk_i bridge with RX/TX pixel FIFOs for spi_core
module spi_pixel_bridge #(
  parameter int WORD_SIZE  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 cs_i,
  input  logic                 rxtx_done_i,
  input  logic [WORD_SIZE-1:0] data_rx_i,
  output logic [WORD_SIZE-1:0] data_tx_o,
  output logic [WORD_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic [WORD_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0]           done_s, cs_s;
  logic                 done_rise, cs_fall;
  logic [WORD_SIZE-1:0] rx_mem [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp, tx_wp, tx_rp;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic                 tx_empty, tx_full, tx_push, tx_pop, tx_load;
  assign done_rise  = done_s[1] & ~done_s[2] & ~cs_s[1];
  assign cs_fall    = ~cs_s[1] & cs_s[2];
  assign rx_empty   = rx_wp == rx_rp;
  assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_empty   = tx_wp == tx_rp;
  assign tx_full    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_valid_o = ~rx_empty;
  assign rx_data_o  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_push    = done_rise & (~rx_full | rx_pop);
  assign tx_ready_o = ~tx_full;
  assign tx_push    = tx_valid_i & ~tx_full;
  assign tx_load    = cs_fall | done_rise;
  assign tx_pop     = tx_load & ~tx_empty;
  // two-stage synchronisers plus one history stage for edge detection
  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) begin
      done_s <= 3'b000;
      cs_s   <= 3'b111;
    end else begin
      done_s <= {done_s[1:0], rxtx_done_i};
      cs_s   <= {cs_s[1:0], cs_i};
    end
  // RX pointers and sticky overflow; a full FIFO still accepts when popped in the same cycle
  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      overflow_o <= 1'b0;
    end else begin
      rx_wp      <= rx_push ? rx_wp + {{AW{1'b0}}, 1'b1} : rx_wp;
      rx_rp      <= rx_pop ? rx_rp + {{AW{1'b0}}, 1'b1} : rx_rp;
      overflow_o <= overflow_o | (done_rise & ~rx_push);
    end
  // RX storage; data_rx_i is quiet for a full sck period after done, so it is sampled unsynchronised
  always_ff @(posedge clk_i)
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= data_rx_i;
  // TX pointers, primed output word and sticky underflow
  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      data_tx_o   <= '0;
      underflow_o <= 1'b0;
    end else begin
      tx_wp       <= tx_push ? tx_wp + {{AW{1'b0}}, 1'b1} : tx_wp;
      tx_rp       <= tx_pop ? tx_rp + {{AW{1'b0}}, 1'b1} : tx_rp;
      data_tx_o   <= tx_load ? (tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]]) : data_tx_o;
      underflow_o <= underflow_o | (tx_load & tx_empty);
    end
  // TX storage
  always_ff @(posedge clk_i)
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data_i;
endmodule
